// File: rtl/mmio_accum_bank_if.sv
// CPU peripheral bus seen by one memory-mapped block: chip enable, write
// strobe, word address, write data and combinational read data.
interface mmio_accum_bank_if #(
    parameter int AW = 4
);
    logic          CE;
    logic          PWE;
    logic [AW-1:0] addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;

    // Handshake: a write commits on the rising clock edge where CE and PWE
    // are both high; rdata is a pure function of addr and state while CE is
    // high and reads zero otherwise. There is no wait state or back-pressure.
    modport master (
        output CE,
        output PWE,
        output addr,
        output wdata,
        input  rdata
    );

    modport slave (
        input  CE,
        input  PWE,
        input  addr,
        input  wdata,
        output rdata
    );
endinterface

// File: rtl/mmio_accum_bank.sv
// Memory-mapped bank of NCH accumulators. Each channel keeps the last word
// written, a wrapping sum, a saturating sample count and sticky OVF/SAT flags.
module mmio_accum_bank #(
    parameter int NCH    = 4,
    parameter int SW     = 32,
    parameter int CW     = 16,
    parameter bit EN_RST = 1'b1
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_accum_bank_if.slave     bus,
    output logic                 ovf_any
);
    localparam int IW  = $clog2(NCH);
    localparam int AW  = IW + 2;
    // Channel-select width stays at least one bit so NCH=1 still elaborates.
    localparam int CSW = (IW > 0) ? IW : 1;

    localparam logic [1:0] REG_DATA  = 2'd0;
    localparam logic [1:0] REG_SUM   = 2'd1;
    localparam logic [1:0] REG_COUNT = 2'd2;
    localparam logic [1:0] REG_CTRL  = 2'd3;

    logic [SW-1:0]  sum_q  [NCH];
    logic [SW-1:0]  sum_d  [NCH];
    logic [CW-1:0]  cnt_q  [NCH];
    logic [CW-1:0]  cnt_d  [NCH];
    logic [31:0]    last_q [NCH];
    logic [31:0]    last_d [NCH];
    logic [NCH-1:0] en_q,  en_d;
    logic [NCH-1:0] ovf_q, ovf_d;
    logic [NCH-1:0] sat_q, sat_d;

    logic [AW-1:0]  addr;
    logic [1:0]     reg_sel;
    logic [31:0]    ch_idx;
    logic [CSW-1:0] ch_sel;
    logic           ch_ok;
    logic           wr_en;
    logic [SW:0]    sum_ext;
    logic [31:0]    rdata_mux;

    // Address decode: channel index in the upper bits, register in the low two.
    assign addr    = bus.addr;
    assign reg_sel = addr[1:0];
    assign ch_idx  = 32'(addr >> 2);
    assign ch_sel  = ch_idx[CSW-1:0];
    assign ch_ok   = (ch_idx < 32'(NCH));
    assign wr_en   = bus.CE & bus.PWE & ch_ok;

    // One extra bit catches the carry out of the top sum bit for OVF.
    assign sum_ext = {1'b0, sum_q[ch_sel]} + {1'b0, bus.wdata[SW-1:0]};

    always_comb begin
        sum_d  = sum_q;
        cnt_d  = cnt_q;
        last_d = last_q;
        en_d   = en_q;
        ovf_d  = ovf_q;
        sat_d  = sat_q;
        if (wr_en) begin
            unique case (reg_sel)
                REG_DATA: begin
                    last_d[ch_sel] = bus.wdata;
                    if (en_q[ch_sel]) begin
                        sum_d[ch_sel] = sum_ext[SW-1:0];
                        if (sum_ext[SW]) begin
                            ovf_d[ch_sel] = 1'b1;
                        end
                        if (&cnt_q[ch_sel]) begin
                            sat_d[ch_sel] = 1'b1;
                        end else begin
                            cnt_d[ch_sel] = cnt_q[ch_sel] + CW'(1);
                        end
                    end
                end
                REG_CTRL: begin
                    // CLR is a strobe; only EN is stored.
                    if (bus.wdata[0]) begin
                        sum_d[ch_sel] = '0;
                        cnt_d[ch_sel] = '0;
                        ovf_d[ch_sel] = 1'b0;
                        sat_d[ch_sel] = 1'b0;
                    end
                    en_d[ch_sel] = bus.wdata[1];
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NCH; i++) begin
                sum_q[i]  <= '0;
                cnt_q[i]  <= '0;
                last_q[i] <= '0;
            end
            en_q  <= {NCH{EN_RST}};
            ovf_q <= '0;
            sat_q <= '0;
        end else begin
            sum_q  <= sum_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            en_q   <= en_d;
            ovf_q  <= ovf_d;
            sat_q  <= sat_d;
        end
    end

    // Zero-latency read of pre-edge state; unmapped channels read as zero.
    always_comb begin
        rdata_mux = '0;
        if (bus.CE && ch_ok) begin
            unique case (reg_sel)
                REG_DATA:  rdata_mux = last_q[ch_sel];
                REG_SUM:   rdata_mux = 32'(sum_q[ch_sel]);
                REG_COUNT: rdata_mux = 32'(cnt_q[ch_sel]);
                REG_CTRL:  rdata_mux = {28'd0, sat_q[ch_sel], ovf_q[ch_sel], en_q[ch_sel], 1'b0};
                default:   rdata_mux = '0;
            endcase
        end
    end

    assign bus.rdata = rdata_mux;
    assign ovf_any   = |ovf_q;

endmodule
